riscv_fetch_queue: RTL and testbench
====================================

RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter DEPTH, default 2: slot count; power of two, at least 2.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 insn_req_valid  out  1  fetch request valid.
REQ-007 insn_req_ready  in  1  memory accepts request.
REQ-008 insn_addr_bus  out  XLEN  fetch address, word aligned.
REQ-009 insn_resp_valid  in  1  response beat valid; in order, no backpressure.
REQ-010 insn_data_bus  in  XLEN  response instruction word.
REQ-011 redirect_valid  in  1  one-cycle pulse: change fetch PC and flush.
REQ-012 redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0.
REQ-013 insn_valid  out  1  instruction valid to decode.
REQ-014 insn_ready  in  1  decode accepts instruction.
REQ-015 insn  out  XLEN  instruction word.
REQ-016 insn_pc  out  XLEN  address of insn.

Function
REQ-017 Request handshake = insn_req_valid && insn_req_ready; output handshake = insn_valid && insn_ready.
REQ-018 Slot allocated at request handshake, storing the current PC; filled in order on insn_resp_valid; freed at output handshake.
REQ-019 insn_req_valid high iff state RUN, no redirect this cycle, and allocated slots < DEPTH.
REQ-020 On request handshake, PC increments by 4 with modulo-2^XLEN wrap (32'hFFFF_FFFC -> 0).
REQ-021 While insn_req_valid is high and not accepted, insn_addr_bus holds; the request is withdrawn only by redirect.
REQ-022 insn_valid high iff the oldest slot is filled; insn/insn_pc come from that slot, registered, no combinational path from inputs.
REQ-023 Minimum latency: response in cycle N -> insn_valid in cycle N+1.
REQ-024 Full queue with pop and request in the same cycle: both proceed and the count is unchanged.
REQ-025 Response with no unfilled allocated slot is a protocol error; assertion only, state unaffected.
REQ-026 States: RUN, DRAIN.
REQ-027 Redirect in any state: PC <= {redirect_pc[XLEN-1:2],2'b00}; all slots freed; insn_valid low next cycle.
REQ-028 Redirect sets stale = number of allocated-but-unfilled slots, including a handshake in that cycle; if stale > 0, state goes to DRAIN, otherwise RUN.
REQ-029 DRAIN: each insn_resp_valid decrements stale, data discarded; at stale = 0, state goes to RUN and requests resume next cycle.
REQ-030 Response coincident with redirect counts as stale-consumed and is discarded.
REQ-031 Redirect overrides a coincident output handshake; the consumed instruction is still the one presented.

Reset
REQ-032 Reset assertion is immediate and asynchronous: state RUN, PC = RESET_PC, all slots free, stale = 0.
REQ-033 Output reset values: insn_req_valid 0, insn_addr_bus RESET_PC, insn_valid 0, insn 0, insn_pc 0.
REQ-034 First request occurs in the first clock after reset deassertion.
REQ-035 Reset mid-transaction abandons in-flight requests; the environment must also reset memory.

Structure
REQ-036 Shared package riscv_pkg: XLEN default, fetch-slot struct {pc, insn, filled}, state enum {RUN, DRAIN}.
REQ-037 Slot storage and pointers (alloc, fill, read) sit in sub-module riscv_fetch_buffer; the top holds PC, FSM and stale counter.

Verification
REQ-038 Reset deasserted, memory ready with 1-cycle latency, decode always ready -> PCs 0,4,8,C issued back to back; insn_pc 0,4,8 in order with matching data.
REQ-039 insn_ready low with DEPTH = 2 -> exactly two requests (0,4), then insn_req_valid low; raise insn_ready -> request 8 in the pop cycle.
REQ-040 Two requests outstanding, redirect_pc = 32'h0000_0103 -> next request 32'h0000_0100 only after both stale responses; no stale data reaches insn_valid.
REQ-041 PC at 32'hFFFF_FFFC -> next request address 32'h0000_0000.
REQ-042 Redirect coincident with a response and an output handshake -> response discarded, stale decrements, insn_valid low next cycle.
REQ-043 Reset asserted in DRAIN with responses pending -> outputs take reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: default data width, fetch-slot record and the
// fetch-queue control states.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] insn;
    logic                    filled;
  } fetch_slot_t;

endpackage

// File: rtl/riscv_fetch_buffer.sv
// In-order slot ring for the fetch queue: slots are allocated at request
// time, filled in order by memory responses and released by decode.
module riscv_fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_flush,
  input  logic                    i_alloc,
  input  logic [XLEN_DEFAULT-1:0] i_alloc_pc,
  input  logic                    i_fill,
  input  logic [XLEN_DEFAULT-1:0] i_fill_insn,
  input  logic                    i_pop,
  output logic [$clog2(DEPTH):0]  o_alloc_cnt,
  output logic [$clog2(DEPTH):0]  o_unfilled_cnt,
  output logic                    o_head_valid,
  output logic [XLEN_DEFAULT-1:0] o_head_insn,
  output logic [XLEN_DEFAULT-1:0] o_head_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  fetch_slot_t r_slots [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]   r_alloc;
  logic [PW:0]   r_fill;
  logic [PW:0]   r_rd;
  logic [PW-1:0] w_alloc_idx;
  logic [PW-1:0] w_fill_idx;
  logic [PW-1:0] w_rd_idx;
  logic          w_fill_ok;

  assign w_alloc_idx = r_alloc[PW-1:0];
  assign w_fill_idx  = r_fill[PW-1:0];
  assign w_rd_idx    = r_rd[PW-1:0];
  assign w_fill_ok   = i_fill && (r_fill != r_alloc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_rd    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slots[i] <= '0;
      end
    end else if (i_flush) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_rd    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_slots[i].filled <= 1'b0;
      end
    end else begin
      // With a full ring, alloc and pop hit the same slot; both clear filled.
      if (i_alloc) begin
        r_slots[w_alloc_idx].pc     <= i_alloc_pc;
        r_slots[w_alloc_idx].filled <= 1'b0;
        r_alloc                     <= r_alloc + PTR_ONE;
      end
      if (w_fill_ok) begin
        r_slots[w_fill_idx].insn   <= i_fill_insn;
        r_slots[w_fill_idx].filled <= 1'b1;
        r_fill                     <= r_fill + PTR_ONE;
      end
      if (i_pop) begin
        r_slots[w_rd_idx].filled <= 1'b0;
        r_rd                     <= r_rd + PTR_ONE;
      end
    end
  end

  assign o_alloc_cnt    = r_alloc - r_rd;
  assign o_unfilled_cnt = r_alloc - r_fill;
  assign o_head_valid   = r_slots[w_rd_idx].filled;
  assign o_head_insn    = r_slots[w_rd_idx].insn;
  assign o_head_pc      = r_slots[w_rd_idx].pc;

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch front end: issues word-aligned fetches, buffers the
// in-order responses for decode and drains stale responses after a redirect.
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            insn_req_valid,
  input  logic            insn_req_ready,
  output logic [XLEN-1:0] insn_addr_bus,
  input  logic            insn_resp_valid,
  input  logic [XLEN-1:0] insn_data_bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] insn_pc
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_stale;
  logic [CW-1:0]   w_stale_nxt;
  logic [CW-1:0]   w_alloc_cnt;
  logic [CW-1:0]   w_unfilled_cnt;
  logic [CW-1:0]   w_outstanding;
  logic            w_pop;
  logic            w_req_valid;
  logic            w_req_hs;
  logic            w_resp_ok;
  logic            w_fill;

  assign w_pop = insn_valid && insn_ready;

  // A pop frees a slot this cycle, so a full queue can still issue.
  assign w_req_valid = reset && (r_state == RUN) && !redirect_valid &&
                       ((w_alloc_cnt < FULL_CNT) || w_pop);
  assign w_req_hs    = w_req_valid && insn_req_ready;

  // Only one of these is ever non-zero: stale in DRAIN, unfilled in RUN.
  assign w_outstanding = r_stale + w_unfilled_cnt;
  assign w_resp_ok     = insn_resp_valid && (w_outstanding != '0);
  assign w_fill        = w_resp_ok && (r_state == RUN) && !redirect_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_stale_nxt = r_stale;
    if (redirect_valid) begin
      w_stale_nxt = w_resp_ok ? (w_outstanding - CNT_ONE) : w_outstanding;
      w_state_nxt = (w_stale_nxt != '0) ? DRAIN : RUN;
    end else if ((r_state == DRAIN) && w_resp_ok) begin
      w_stale_nxt = r_stale - CNT_ONE;
      if (r_stale == CNT_ONE) begin
        w_state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_stale <= '0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_stale <= w_stale_nxt;
      if (redirect_valid) begin
        r_pc <= redirect_pc & ALIGN_MASK;
      end else if (w_req_hs) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  riscv_fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock          (clock),
    .reset          (reset),
    .i_flush        (redirect_valid),
    .i_alloc        (w_req_hs),
    .i_alloc_pc     (r_pc),
    .i_fill         (w_fill),
    .i_fill_insn    (insn_data_bus),
    .i_pop          (w_pop),
    .o_alloc_cnt    (w_alloc_cnt),
    .o_unfilled_cnt (w_unfilled_cnt),
    .o_head_valid   (insn_valid),
    .o_head_insn    (insn),
    .o_head_pc      (insn_pc)
  );

  assign insn_req_valid = w_req_valid;
  assign insn_addr_bus  = r_pc;

  // A response with nothing outstanding is a memory-side protocol error.
  resp_has_owner : assert property (@(posedge clock) disable iff (!reset)
    !(insn_resp_valid && (w_outstanding == '0)));

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: per-cycle vector table plus directed redirect,
// wrap and reset sequences, with a scoreboard on the decode side.
module tb_riscv_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        insn_req_valid;
  logic        insn_req_ready;
  logic [31:0] insn_addr_bus;
  logic        insn_resp_valid;
  logic [31:0] insn_data_bus;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;

  riscv_fetch_queue #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .insn_req_valid  (insn_req_valid),
    .insn_req_ready  (insn_req_ready),
    .insn_addr_bus   (insn_addr_bus),
    .insn_resp_valid (insn_resp_valid),
    .insn_data_bus   (insn_data_bus),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .insn_valid      (insn_valid),
    .insn_ready      (insn_ready),
    .insn            (insn),
    .insn_pc         (insn_pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          mem_ready;
    bit          dec_ready;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] mem_q[$];
  logic [31:0] model_pc;

  bit          g_mem_ready;
  bit          g_dec_ready;
  bit          g_hold;
  bit          g_redir;
  logic [31:0] g_redir_pc;

  logic        s_rv;
  logic        s_iv;
  logic [31:0] s_addr;
  logic [31:0] s_ipc;

  vec_t tbl [14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called at a falling edge: drive inputs, sample, update models, advance one cycle.
  task automatic tick();
    exp_t e;
    insn_req_ready = g_mem_ready;
    insn_ready     = g_dec_ready;
    redirect_valid = g_redir;
    redirect_pc    = g_redir_pc;
    if (!g_hold && (mem_q.size() > 0)) begin
      insn_resp_valid = 1'b1;
      insn_data_bus   = mem_word(mem_q[0]);
    end else begin
      insn_resp_valid = 1'b0;
      insn_data_bus   = '0;
    end
    #1;
    s_rv   = insn_req_valid;
    s_addr = insn_addr_bus;
    s_iv   = insn_valid;
    s_ipc  = insn_pc;
    if (insn_valid && insn_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_insn: got pc %h, expected no instruction", insn_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", insn_pc, e.pc);
        chk("out_insn", insn, e.word);
      end
    end
    if (insn_resp_valid) void'(mem_q.pop_front());
    if (insn_req_valid && insn_req_ready) begin
      chk("req_addr", insn_addr_bus, model_pc);
      mem_q.push_back(model_pc);
      sb.push_back('{model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (redirect_valid) begin
      sb.delete();
      model_pc = redirect_pc & ~32'h3;
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input bit check_vals);
    reset           = 1'b0;
    insn_req_ready  = 1'b0;
    insn_ready      = 1'b0;
    insn_resp_valid = 1'b0;
    insn_data_bus   = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    #1;
    if (check_vals) begin
      chk("rst_req_valid", 32'(insn_req_valid), 32'd0);
      chk("rst_addr", insn_addr_bus, RST_PC);
      chk("rst_insn_valid", 32'(insn_valid), 32'd0);
      chk("rst_insn", insn, 32'd0);
      chk("rst_insn_pc", insn_pc, 32'd0);
    end
    mem_q.delete();
    sb.delete();
    model_pc = RST_PC;
    g_redir  = 1'b0;
    g_hold   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst, mem_ready, dec_ready, exp_req_valid, exp_addr, exp_insn_valid, exp_insn_pc
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

    reset           = 1'b1;
    insn_req_ready  = 1'b0;
    insn_ready      = 1'b0;
    insn_resp_valid = 1'b0;
    insn_data_bus   = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    g_redir_pc      = '0;
    model_pc        = RST_PC;
    #3;
    do_reset(1'b1);

    // Back-to-back streaming, then decode backpressure with a full queue.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst && (i != 0)) do_reset(1'b0);
      g_mem_ready = tbl[i].mem_ready;
      g_dec_ready = tbl[i].dec_ready;
      g_hold      = 1'b0;
      g_redir     = 1'b0;
      tick();
      chk($sformatf("row%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].exp_rv));
      chk($sformatf("row%0d_addr", i), s_addr, tbl[i].exp_addr);
      chk($sformatf("row%0d_insn_valid", i), 32'(s_iv), 32'(tbl[i].exp_iv));
      chk($sformatf("row%0d_insn_pc", i), s_ipc, tbl[i].exp_ipc);
    end

    // Redirect with two responses outstanding: drain both before refetching.
    do_reset(1'b0);
    g_mem_ready = 1'b1;
    g_dec_ready = 1'b1;
    g_hold      = 1'b1;
    tick();
    tick();
    g_redir    = 1'b1;
    g_redir_pc = 32'h0000_0103;
    tick();
    chk("drain_redir_req_valid", 32'(s_rv), 32'd0);
    g_redir = 1'b0;
    for (int k = 0; k < 5; k++) begin
      g_hold = !((k == 2) || (k == 4));
      tick();
      chk($sformatf("drain%0d_req_valid", k), 32'(s_rv), 32'd0);
      chk($sformatf("drain%0d_insn_valid", k), 32'(s_iv), 32'd0);
    end
    g_hold = 1'b0;
    tick();
    chk("drain_resume_req_valid", 32'(s_rv), 32'd1);
    chk("drain_resume_addr", s_addr, 32'h0000_0100);
    tick();
    tick();
    chk("drain_new_insn_valid", 32'(s_iv), 32'd1);
    chk("drain_new_insn_pc", s_ipc, 32'h0000_0100);
    tick();

    // Redirect coincident with a response and a decode handshake.
    do_reset(1'b0);
    g_mem_ready = 1'b1;
    g_dec_ready = 1'b0;
    tick();
    tick();
    g_dec_ready = 1'b1;
    g_redir     = 1'b1;
    g_redir_pc  = 32'h0000_0200;
    tick();
    chk("coinc_req_valid", 32'(s_rv), 32'd0);
    chk("coinc_insn_valid", 32'(s_iv), 32'd1);
    chk("coinc_insn_pc", s_ipc, 32'h0000_0000);
    g_redir = 1'b0;
    tick();
    chk("coinc_next_insn_valid", 32'(s_iv), 32'd0);
    chk("coinc_next_req_valid", 32'(s_rv), 32'd1);
    chk("coinc_next_addr", s_addr, 32'h0000_0200);
    repeat (4) tick();

    // Address wrap from the top of the address space.
    do_reset(1'b0);
    g_mem_ready = 1'b0;
    g_dec_ready = 1'b1;
    g_redir     = 1'b1;
    g_redir_pc  = 32'hFFFF_FFFC;
    tick();
    g_redir     = 1'b0;
    g_mem_ready = 1'b1;
    tick();
    chk("wrap_first_addr", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_second_addr", s_addr, 32'h0000_0000);
    repeat (4) tick();

    // Asynchronous reset while draining stale responses.
    do_reset(1'b0);
    g_mem_ready = 1'b0;
    g_dec_ready = 1'b1;
    g_redir     = 1'b1;
    g_redir_pc  = 32'h0000_0040;
    tick();
    g_redir     = 1'b0;
    g_mem_ready = 1'b1;
    g_hold      = 1'b1;
    tick();
    tick();
    g_redir    = 1'b1;
    g_redir_pc = 32'h0000_0300;
    tick();
    g_redir = 1'b0;
    tick();
    chk("rstdrain_req_valid", 32'(s_rv), 32'd0);
    chk("rstdrain_addr", s_addr, 32'h0000_0300);
    #2;
    do_reset(1'b1);
    g_mem_ready = 1'b1;
    g_dec_ready = 1'b1;
    tick();
    chk("restart_req_valid", 32'(s_rv), 32'd1);
    chk("restart_addr", s_addr, RST_PC);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
